fir_output_decimator: RTL and testbench

//  Downstream stage of transposed_filter: consumes filtered_signal (signed 32b, one result per clk).

---
 rtl/fir_output_decimator_pkg.sv | 17 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/fir_output_decimator.sv | 135 +++++++++++++
 tb/tb_fir_output_decimator.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_output_decimator_pkg.sv
// Shared types and defaults for the FIR output decimator.
// Widths, output limits and FSM state encodings.
package fir_output_decimator_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 15;

  localparam logic signed [15:0] OUT_MAX = 16'sh7fff;
  localparam logic signed [15:0] OUT_MIN = 16'sh8000;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Write is refused when full unless a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr;
  logic             rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

endmodule

// File: rtl/fir_output_decimator.sv
// Drops filter warm-up, rounds/saturates to OUT_W, decimates by DECIM
// and streams kept samples out of a small FWFT FIFO.
module fir_output_decimator
  import fir_output_decimator_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_en,
  input  logic [IN_W-1:0] in_data,
  output logic [OUT_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            running,
  output logic            sat_flag,
  output logic            overflow
);

  localparam int WCW = $clog2(WARMUP + 2);
  localparam int PW  = $clog2(DECIM + 1);

  localparam logic signed [IN_W:0] RND =
    (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] HI =
    (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] LO = -HI - 1;

  state_t           state;
  state_t           state_nx;
  logic [WCW-1:0]   wcnt;
  logic [PW-1:0]    phase;
  logic             keep;

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] r;
  logic                 clip;
  logic [OUT_W-1:0]     sval;

  logic             s1_keep;
  logic [OUT_W-1:0] s1_data;

  logic [OUT_W-1:0] f_dout;
  logic             f_full;
  logic             f_empty;
  logic [$clog2(FIFO_DEPTH):0] f_cnt;
  logic             pop;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WARMUP;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_WARMUP: begin
        if (WARMUP == 0)
          state_nx = ST_RUN;
        else if (in_en && wcnt == WCW'(WARMUP - 1))
          state_nx = ST_RUN;
      end
      ST_RUN: state_nx = ST_RUN;
      default: state_nx = ST_WARMUP;
    endcase
  end

  assign running = (state == ST_RUN);
  assign keep    = running && in_en && (phase == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt  <= '0;
      phase <= '0;
    end else begin
      if (!running && in_en) wcnt <= wcnt + 1'b1;
      if (running && in_en)
        phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
    end
  end

  // Sign-extend one bit so the rounding add cannot wrap.
  always_comb begin
    ext  = {in_data[IN_W-1], in_data} + RND;
    r    = ext >>> SHIFT;
    clip = 1'b0;
    sval = r[OUT_W-1:0];
    if (r > HI) begin
      clip = 1'b1;
      sval = HI[OUT_W-1:0];
    end else if (r < LO) begin
      clip = 1'b1;
      sval = LO[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_keep  <= 1'b0;
      s1_data  <= '0;
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1_keep <= keep;
      s1_data <= sval;
      if (keep && clip) sat_flag <= 1'b1;
      if (s1_keep && f_full && !pop) overflow <= 1'b1;
    end
  end

  assign out_valid = (f_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = f_empty ? '0 : f_dout;

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_keep),
    .pop   (pop),
    .din   (s1_data),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed bench for fir_output_decimator: warm-up, rounding,
// saturation, backpressure, in_en gaps and mid-stream reset.
module tb_fir_output_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en;
  logic [31:0] in_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        running;
  logic        sat_flag;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  logic [15:0] got[$];

  always #5 clk = ~clk;

  fir_output_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .running   (running),
    .sat_flag  (sat_flag),
    .overflow  (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_en = 1'b0;
    in_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_in(input logic [31:0] d);
    in_en = 1'b1;
    in_data = d;
    step();
    in_en = 1'b0;
  endtask

  task automatic warm();
    do_reset();
    repeat (16) push_in(32'd0);
  endtask

  task automatic kept(input logic [31:0] d);
    push_in(d);
    repeat (3) push_in(32'd0);
  endtask

  // Ramp k<<15; with gaps, in_en alternates 1,0 and gap data is junk.
  task automatic ramp(input bit gaps, output int rise, output int first);
    int idx;
    int n;
    idx = 0;
    rise = -1;
    first = -1;
    n = gaps ? 64 : 32;
    got.delete();
    for (int c = 0; c < n; c++) begin
      if (!gaps || (c % 2 == 0)) begin
        in_en = 1'b1;
        in_data = 32'(idx) << 15;
        idx++;
      end else begin
        in_en = 1'b0;
        in_data = 32'h1234_5678;
      end
      step();
      if (running && rise < 0) rise = c;
      if (out_valid) begin
        if (first < 0) first = c;
        got.push_back(out_data);
      end
    end
    in_en = 1'b0;
  endtask

  task automatic check_ramp(input string nm, input int rise, input int first,
                            input int erise, input int efirst);
    checks++;
    if (rise !== erise) begin
      failures++;
      $display("FAIL %s_running_rise got=%0d exp=%0d", nm, rise, erise);
    end
    checks++;
    if (first !== efirst) begin
      failures++;
      $display("FAIL %s_first_valid got=%0d exp=%0d", nm, first, efirst);
    end
    checks++;
    if (got.size() !== 4) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=4", nm, got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 16'(16 + 4*i)) begin
        failures++;
        $display("FAIL %s_out%0d got=%0d exp=%0d", nm, i, got[i], 16 + 4*i);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, running, sat_flag, overflow} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {out_valid, running, sat_flag, overflow});
    end
    checks++;
    if (out_data !== 16'd0) begin
      failures++;
      $display("FAIL reset_data got=%0d exp=0", out_data);
    end
  endtask

  task automatic test_warmup();
    int rise;
    int first;
    do_reset();
    out_ready = 1'b1;
    ramp(1'b0, rise, first);
    check_ramp("warmup", rise, first, 15, 17);
  endtask

  task automatic test_rounding();
    logic [31:0] vin[4] = '{32'd16384, 32'd16383, 32'hffff_c000, 32'hffff_bfff};
    logic [15:0] exp[4] = '{16'd1, 16'd0, 16'd0, 16'hffff};
    out_ready = 1'b1;
    warm();
    for (int i = 0; i < 4; i++) begin
      push_in(vin[i]);
      push_in(32'd0);
      checks++;
      if (!out_valid || out_data !== exp[i]) begin
        failures++;
        $display("FAIL round%0d got=%h/v%b exp=%h", i, out_data, out_valid, exp[i]);
      end
      push_in(32'd0);
      push_in(32'd0);
    end
    checks++;
    if (sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL round_sat got=%b exp=0", sat_flag);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    warm();
    push_in(32'h4000_0000);
    push_in(32'd0);
    checks++;
    if (!out_valid || out_data !== 16'h7fff || sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos got=%h sat=%b exp=7fff sat=1", out_data, sat_flag);
    end
    push_in(32'd0);
    push_in(32'd0);
    push_in(32'hc000_0000);
    push_in(32'd0);
    checks++;
    if (!out_valid || out_data !== 16'h8000 || sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg got=%h sat=%b exp=8000 sat=1", out_data, sat_flag);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    warm();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) kept(32'(i) << 15);
    checks++;
    if (overflow !== 1'b0 || !out_valid || out_data !== 16'd1) begin
      failures++;
      $display("FAIL bp_full got=%0d ovf=%b exp=1 ovf=0", out_data, overflow);
    end
    kept(32'd5 << 15);
    checks++;
    if (overflow !== 1'b1 || out_data !== 16'd1) begin
      failures++;
      $display("FAIL bp_drop got=%0d ovf=%b exp=1 ovf=1", out_data, overflow);
    end
    out_ready = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      checks++;
      if (!out_valid || out_data !== 16'(e)) begin
        failures++;
        $display("FAIL bp_drain%0d got=%0d/v%b exp=%0d", e, out_data, out_valid, e);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin
      failures++;
      $display("FAIL bp_empty got=%0d/v%b exp=0/v0", out_data, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    warm();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) kept(32'(i) << 15);
    push_in(32'd5 << 15);
    out_ready = 1'b1;
    push_in(32'd0);
    out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || out_data !== 16'd2) begin
      failures++;
      $display("FAIL b2b_pushpop got=%0d ovf=%b exp=2 ovf=0", out_data, overflow);
    end
    out_ready = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      checks++;
      if (!out_valid || out_data !== 16'(e)) begin
        failures++;
        $display("FAIL b2b_drain%0d got=%0d/v%b exp=%0d", e, out_data, out_valid, e);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_gaps();
    int rise;
    int first;
    do_reset();
    out_ready = 1'b1;
    ramp(1'b1, rise, first);
    check_ramp("gaps", rise, first, 30, 33);
  endtask

  task automatic test_reset_mid();
    int rise;
    int first;
    out_ready = 1'b1;
    warm();
    out_ready = 1'b0;
    kept(32'd1 << 15);
    kept(32'd2 << 15);
    kept(32'h4000_0000);
    kept(32'd4 << 15);
    kept(32'd5 << 15);
    checks++;
    if ({out_valid, sat_flag, overflow} !== 3'b111) begin
      failures++;
      $display("FAIL rmid_pre got=%b exp=111", {out_valid, sat_flag, overflow});
    end
    rst = 1'b1;
    in_en = 1'b1;
    in_data = 32'd7 << 15;
    step();
    rst = 1'b0;
    in_en = 1'b0;
    checks++;
    if ({out_valid, running, sat_flag, overflow} !== 4'b0000 ||
        out_data !== 16'd0) begin
      failures++;
      $display("FAIL rmid_post got=%b data=%0d exp=0000 data=0",
               {out_valid, running, sat_flag, overflow}, out_data);
    end
    out_ready = 1'b1;
    ramp(1'b0, rise, first);
    check_ramp("rmid", rise, first, 15, 17);
  endtask

  initial begin
    rst = 1'b1;
    in_en = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_warmup();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
